sc_lifeloss_ctrl: RTL

- Producer side of the life-counter decrement interface.
- Turns raw frog-hazard collision and level-timeout events into exactly one single-cycle decrement pulse per death.
- Sequences the death animation, respawn and post-respawn invulnerability, and latches game-over when lives are exhausted.
- Sits between the collision/playfield logic and the life counter; it reads back the counter's 4-bit value.

---
 rtl/sc_lifeloss_ctrl_pkg.sv | 24 ++
 rtl/sc_lifeloss_tickcnt.sv | 26 ++
 rtl/sc_lifeloss_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sc_lifeloss_ctrl_pkg.sv
// Shared types and defaults for the life-loss controller: FSM state encoding,
// lives bus width and default tick budgets.
package sc_lifeloss_ctrl_pkg;

  localparam int LIVES_W          = 4;
  localparam int TICK_W_DEF       = 8;
  localparam int DEATH_TICKS_DEF  = 30;
  localparam int INVULN_TICKS_DEF = 60;

  typedef enum logic [2:0] {
    PLAY       = 3'd0,
    HIT        = 3'd1,
    DYING      = 3'd2,
    RESPAWN_ST = 3'd3,
    INVULN     = 3'd4,
    GAMEOVER   = 3'd5
  } sc_state_e;

  // The tick counter only advances in the two timed phases.
  function automatic logic is_counting(input sc_state_e s);
    return (s == DYING) || (s == INVULN);
  endfunction

endpackage

// File: rtl/sc_lifeloss_tickcnt.sv
// Loadable frame-tick down-counter; LAST flags the tick that consumes the final count.
module sc_lifeloss_tickcnt #(
  parameter int TICK_W = 8
) (
  input  logic              SC_TICKCNT_CLOCK_50,
  input  logic              SC_TICKCNT_RESET_InLow,
  input  logic              SC_TICKCNT_LOAD,
  input  logic [TICK_W-1:0] SC_TICKCNT_LOAD_InBUS,
  input  logic              SC_TICKCNT_EN,
  output logic [TICK_W-1:0] SC_TICKCNT_VALUE,
  output logic              SC_TICKCNT_LAST
);

  always_ff @(posedge SC_TICKCNT_CLOCK_50 or negedge SC_TICKCNT_RESET_InLow) begin
    if (!SC_TICKCNT_RESET_InLow) begin
      SC_TICKCNT_VALUE <= '0;
    end else if (SC_TICKCNT_LOAD) begin
      SC_TICKCNT_VALUE <= SC_TICKCNT_LOAD_InBUS;
    end else if (SC_TICKCNT_EN) begin
      SC_TICKCNT_VALUE <= SC_TICKCNT_VALUE - 1'b1;
    end
  end

  assign SC_TICKCNT_LAST = SC_TICKCNT_EN && (SC_TICKCNT_VALUE == TICK_W'(1));

endmodule

// File: rtl/sc_lifeloss_ctrl.sv
// Life-loss controller: one CUENTA pulse per death, then death animation, respawn,
// invulnerability, or sticky game-over. Define SC_LIFELOSS_COLLISION_SYNC_EN to synchronise the hazard inputs.
module sc_lifeloss_ctrl
  import sc_lifeloss_ctrl_pkg::*;
#(
  parameter int                 TICK_W       = TICK_W_DEF,
  parameter logic [TICK_W-1:0]  DEATH_TICKS  = TICK_W'(DEATH_TICKS_DEF),
  parameter logic [TICK_W-1:0]  INVULN_TICKS = TICK_W'(INVULN_TICKS_DEF)
) (
  input  logic               SC_LIFELOSS_CLOCK_50,
  input  logic               SC_LIFELOSS_RESET_InLow,
  input  logic               SC_LIFELOSS_TICK,
  input  logic               SC_LIFELOSS_COLLISION,
  input  logic               SC_LIFELOSS_TIMEOUT,
  input  logic [LIVES_W-1:0] SC_LIFELOSS_LIVES_InBUS,
  output logic               SC_LIFELOSS_CUENTA,
  output logic               SC_LIFELOSS_RESPAWN,
  output logic               SC_LIFELOSS_DYING,
  output logic               SC_LIFELOSS_INVULNERABLE,
  output logic               SC_LIFELOSS_GAMEOVER,
  output logic [2:0]         SC_LIFELOSS_STATE_DBG
);

  sc_state_e         state;
  logic              hazard_evt;
  logic              cnt_load;
  logic [TICK_W-1:0] cnt_load_val;
  logic              cnt_en;
  logic [TICK_W-1:0] cnt_value;
  logic              cnt_last;
  logic              lives_zero;

`ifdef SC_LIFELOSS_COLLISION_SYNC_EN
  logic [1:0] collision_sync;
  logic [1:0] timeout_sync;

  always_ff @(posedge SC_LIFELOSS_CLOCK_50 or negedge SC_LIFELOSS_RESET_InLow) begin
    if (!SC_LIFELOSS_RESET_InLow) begin
      collision_sync <= 2'b00;
      timeout_sync   <= 2'b00;
    end else begin
      collision_sync <= {collision_sync[0], SC_LIFELOSS_COLLISION};
      timeout_sync   <= {timeout_sync[0], SC_LIFELOSS_TIMEOUT};
    end
  end

  assign hazard_evt = collision_sync[1] | timeout_sync[1];
`else
  assign hazard_evt = SC_LIFELOSS_COLLISION | SC_LIFELOSS_TIMEOUT;
`endif

  assign lives_zero = (SC_LIFELOSS_LIVES_InBUS == '0);

  // Loads happen in the one-cycle states, so a tick landing there is never counted.
  assign cnt_load     = (state == HIT) || ((state == RESPAWN_ST) && (INVULN_TICKS != '0));
  assign cnt_load_val = (state == HIT) ? DEATH_TICKS : INVULN_TICKS;
  assign cnt_en       = SC_LIFELOSS_TICK && is_counting(state);

  sc_lifeloss_tickcnt #(
    .TICK_W (TICK_W)
  ) u_tickcnt (
    .SC_TICKCNT_CLOCK_50    (SC_LIFELOSS_CLOCK_50),
    .SC_TICKCNT_RESET_InLow (SC_LIFELOSS_RESET_InLow),
    .SC_TICKCNT_LOAD        (cnt_load),
    .SC_TICKCNT_LOAD_InBUS  (cnt_load_val),
    .SC_TICKCNT_EN          (cnt_en),
    .SC_TICKCNT_VALUE       (cnt_value),
    .SC_TICKCNT_LAST        (cnt_last)
  );

  always_ff @(posedge SC_LIFELOSS_CLOCK_50 or negedge SC_LIFELOSS_RESET_InLow) begin
    if (!SC_LIFELOSS_RESET_InLow) begin
      state                    <= PLAY;
      SC_LIFELOSS_CUENTA       <= 1'b0;
      SC_LIFELOSS_RESPAWN      <= 1'b0;
      SC_LIFELOSS_DYING        <= 1'b0;
      SC_LIFELOSS_INVULNERABLE <= 1'b0;
      SC_LIFELOSS_GAMEOVER     <= 1'b0;
    end else begin
      SC_LIFELOSS_CUENTA  <= 1'b0;
      SC_LIFELOSS_RESPAWN <= 1'b0;
      case (state)
        PLAY: begin
          if (hazard_evt) begin
            // With no lives left the counter must not be decremented (0 would wrap to 15).
            if (!lives_zero) begin
              state              <= HIT;
              SC_LIFELOSS_CUENTA <= 1'b1;
            end else begin
              state                <= GAMEOVER;
              SC_LIFELOSS_GAMEOVER <= 1'b1;
            end
          end
        end
        HIT: begin
          state             <= DYING;
          SC_LIFELOSS_DYING <= 1'b1;
        end
        DYING: begin
          if (cnt_last) begin
            SC_LIFELOSS_DYING <= 1'b0;
            if (lives_zero) begin
              state                <= GAMEOVER;
              SC_LIFELOSS_GAMEOVER <= 1'b1;
            end else begin
              state               <= RESPAWN_ST;
              SC_LIFELOSS_RESPAWN <= 1'b1;
            end
          end
        end
        RESPAWN_ST: begin
          if (INVULN_TICKS != '0) begin
            state                    <= INVULN;
            SC_LIFELOSS_INVULNERABLE <= 1'b1;
          end else begin
            state <= PLAY;
          end
        end
        INVULN: begin
          if (cnt_last) begin
            state                    <= PLAY;
            SC_LIFELOSS_INVULNERABLE <= 1'b0;
          end
        end
        GAMEOVER: begin
          SC_LIFELOSS_GAMEOVER <= 1'b1;
        end
        default: begin
          state                    <= PLAY;
          SC_LIFELOSS_DYING        <= 1'b0;
          SC_LIFELOSS_INVULNERABLE <= 1'b0;
          SC_LIFELOSS_GAMEOVER     <= 1'b0;
        end
      endcase
    end
  end

  assign SC_LIFELOSS_STATE_DBG = state;

endmodule
